// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: FSM state and mode codes.
package interval_timer_ctrl_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;

    // 2'b11 is unused and recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic {
        M_ONESHOT  = 1'b0,
        M_PERIODIC = 1'b1
    } mode_e;

endpackage

// File: rtl/interval_timer_ctrl_counter_nb.sv
// N-bit binary counter built from a ripple chain of b2_counter cells.
// Enable ei, synchronous clear clr (dominant), carry-out eu; no control logic.
module interval_timer_ctrl_counter_nb #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         ei,
    input  logic         clr,
    output logic [N-1:0] q,
    output logic         eu
);

    logic [N:0]   carry;
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    assign carry[0] = ei;

    // One b2_counter cell per bit: toggle on incoming carry, clr gates next value
    for (genvar i = 0; i < int'(N); i++) begin : g_b2_counter
        assign q_d[i]       = clr ? 1'b0 : (q_q[i] ^ carry[i]);
        assign carry[i + 1] = carry[i] & q_q[i];
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign eu = carry[N];

endmodule

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: req/ack host handshake sequencing an N-bit counter
// through 0..LIM with one-shot or periodic behaviour and a terminal-count tick.
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int unsigned N = CNT_W_DEFAULT
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         req,
    input  logic [N-1:0] limit,
    input  logic         mode,
    output logic         ack,
    output logic         busy,
    output logic [N-1:0] count,
    output logic         tick
);

    state_e       state_q, state_d;
    logic [N-1:0] lim_q, lim_d;
    mode_e        mode_q, mode_d;

    logic         cnt_ei;
    logic         cnt_clr;
    logic         at_lim;
    logic         carry_unused;

    interval_timer_ctrl_counter_nb #(.N(N)) u_counter (
        .clock  (clock),
        .reset_ (reset_),
        .ei     (cnt_ei),
        .clr    (cnt_clr),
        .q      (count),
        .eu     (carry_unused)
    );

    assign at_lim = (count == lim_q);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            lim_q   <= '0;
            mode_q  <= M_ONESHOT;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
        end
    end

    // Next state; limit and mode are captured only on the IDLE->COUNT edge
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_COUNT;
                    lim_d   = limit;
                    mode_d  = mode_e'(mode);
                end
            end
            S_COUNT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (at_lim && (mode_q == M_ONESHOT)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter control plus Moore status decoded from registers only
    always_comb begin
        cnt_ei  = 1'b0;
        cnt_clr = 1'b0;
        tick    = 1'b0;
        ack     = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
            end
            S_COUNT: begin
                busy = 1'b1;
                tick = at_lim;
                if (!req) begin
                    cnt_clr = 1'b1;
                end else if (!at_lim) begin
                    cnt_ei = 1'b1;
                end else if (mode_q == M_PERIODIC) begin
                    cnt_clr = 1'b1;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                ack     = 1'b1;
                cnt_clr = !req;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: driver pushes model predictions,
// monitor pops and compares one cycle-sample per clock.
module tb_interval_timer_ctrl;

    localparam int unsigned N = 4;

    typedef struct {
        logic [N-1:0] count;
        logic         tick;
        logic         ack;
        logic         busy;
    } obs_t;

    logic         clock;
    logic         reset_;
    logic         req;
    logic [N-1:0] limit;
    logic         mode;
    logic         ack;
    logic         busy;
    logic [N-1:0] count;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t sb_q[$];

    // Reference: a transaction is "cycles since start" k; count follows from k
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_lim    = 0;
    bit m_per    = 1'b0;

    interval_timer_ctrl #(.N(N)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .req    (req),
        .limit  (limit),
        .mode   (mode),
        .ack    (ack),
        .busy   (busy),
        .count  (count),
        .tick   (tick)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic bit m_done();
        return m_active && !m_per && (m_k > m_lim);
    endfunction

    function automatic void model_edge(input bit r, input int lmt, input bit md);
        if (!m_active) begin
            if (r) begin
                m_active = 1'b1;
                m_k      = 0;
                m_lim    = lmt;
                m_per    = md;
            end
        end else if (!r) begin
            m_active = 1'b0;
        end else if (!m_done()) begin
            m_k++;
        end
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   c;
        o.count = '0;
        o.tick  = 1'b0;
        o.ack   = 1'b0;
        o.busy  = 1'b0;
        if (m_active) begin
            o.busy = 1'b1;
            if (m_done()) begin
                o.ack   = 1'b1;
                o.count = N'(m_lim);
            end else begin
                c       = m_per ? (m_k % (m_lim + 1)) : m_k;
                o.count = N'(c);
                o.tick  = (c == m_lim);
            end
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got.count !== exp.count || got.tick !== exp.tick ||
            got.ack !== exp.ack || got.busy !== exp.busy) begin
            n_fail++;
            $display("FAIL %s @%0t: got count=%0d tick=%b ack=%b busy=%b, want count=%0d tick=%b ack=%b busy=%b",
                     name, $time, got.count, got.tick, got.ack, got.busy,
                     exp.count, exp.tick, exp.ack, exp.busy);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.count = count;
        o.tick  = tick;
        o.ack   = ack;
        o.busy  = busy;
        return o;
    endfunction

    function automatic obs_t zero_obs();
        obs_t o;
        o.count = '0;
        o.tick  = 1'b0;
        o.ack   = 1'b0;
        o.busy  = 1'b0;
        return o;
    endfunction

    // Monitor: every clock presents one observation
    initial begin
        obs_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_obs("cycle", sample(), e);
            end
        end
    end

    task automatic step(input bit r, input int lmt, input bit md);
        @(negedge clock);
        req   = r;
        limit = N'(lmt);
        mode  = md;
        @(posedge clock);
        model_edge(r, lmt, md);
        sb_q.push_back(model_out());
    endtask

    task automatic steps(input int n, input bit r, input int lmt, input bit md);
        for (int i = 0; i < n; i++) step(r, lmt, md);
    endtask

    // Asynchronous reset between edges, then restart with new inputs
    task automatic reset_mid(input bit r, input int lmt, input bit md);
        @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        check_obs("async_reset", sample(), zero_obs());
        m_active = 1'b0;
        req      = r;
        limit    = N'(lmt);
        mode     = md;
        #1 reset_ = 1'b1;
        @(posedge clock);
        model_edge(r, lmt, md);
        sb_q.push_back(model_out());
    endtask

    initial begin
        reset_ = 1'b1;
        req    = 1'b0;
        limit  = '0;
        mode   = 1'b0;
        #1 reset_ = 1'b0;
        #2;
        check_obs("reset_state", sample(), zero_obs());
        @(negedge clock);
        reset_ = 1'b1;

        // One-shot limit 5, hold through ack, then release
        steps(9, 1'b1, 5, 1'b0);
        steps(2, 1'b0, 5, 1'b0);

        // Periodic limit 2, abort mid-count
        steps(8, 1'b1, 2, 1'b1);
        steps(2, 1'b0, 2, 1'b1);

        // Periodic limit 0, then one-shot at full range
        steps(5, 1'b1, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        steps(19, 1'b1, 15, 1'b0);
        steps(2, 1'b0, 15, 1'b0);

        // Reset at count 3, restart with a new limit
        steps(4, 1'b1, 7, 1'b0);
        reset_mid(1'b1, 4, 1'b0);
        steps(7, 1'b1, 4, 1'b0);
        step(1'b0, 4, 1'b0);

        // Limit changed during COUNT is ignored; back-to-back restart
        step(1'b1, 5, 1'b0);
        steps(8, 1'b1, 9, 1'b0);
        step(1'b0, 9, 1'b0);
        steps(12, 1'b1, 9, 1'b0);
        step(1'b0, 9, 1'b0);

        // Illegal-free random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_mid($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                          $urandom_range(0, 1) == 1);
            end else begin
                step($urandom_range(0, 99) < 88, int'($urandom_range(0, 15)),
                     $urandom_range(0, 1) == 1);
            end
        end
        step(1'b0, 0, 1'b0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d observations still pending, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
